pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch/PC control sequencer: drives PC commands, issues fetch requests with a
// bounded wait for acknowledge, and applies pending jumps after each fetch.
module pc_sequencer #(
  parameter int ANCHO   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             jump_req_i,
  input  logic [ANCHO-1:0] jump_addr_i,
  input  logic [ANCHO-1:0] pc_val_i,
  input  logic             mem_ack_i,
  output logic [1:0]       pc_op_o,
  output logic [ANCHO-1:0] pc_target_o,
  output logic             mem_req_o,
  output logic [ANCHO-1:0] fetch_addr_o,
  output logic             instr_valid_o,
  output logic             busy_o,
  output logic             error_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_ADVANCE = 3'd3;
  localparam logic [2:0] S_JUMP    = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_HOLD  = 2'b01;
  localparam logic [1:0] OP_INC   = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT);

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [7:0]       timer;
  logic             jump_pending;
  logic [ANCHO-1:0] jump_addr_q;
  logic [ANCHO-1:0] target_q;
  logic             instr_valid_q;

  logic fetch_done;
  logic timed_out;
  logic issuing_jump;
  logic sample_jump;

  assign fetch_done   = (state == S_FETCH) && mem_ack_i;
  assign timed_out    = (state == S_FETCH) && !mem_ack_i && ((timer + 8'd1) == TIMEOUT_LIMIT);
  assign issuing_jump = (state == S_JUMP) && !stall_i;
  assign sample_jump  = jump_req_i &&
                        ((state == S_FETCH) || (state == S_ADVANCE) || (state == S_JUMP));

  // start_i restarts from any state; a jump requested alongside the ack still counts
  always_comb begin
    state_next = state;
    if (start_i) begin
      state_next = S_CLEAR;
    end else begin
      case (state)
        S_IDLE:    state_next = S_IDLE;
        S_CLEAR:   state_next = S_FETCH;
        S_FETCH: begin
          if (mem_ack_i)
            state_next = (jump_pending || jump_req_i) ? S_JUMP : S_ADVANCE;
          else if (timed_out)
            state_next = S_ERROR;
        end
        S_ADVANCE: if (!stall_i) state_next = S_FETCH;
        S_JUMP:    if (!stall_i) state_next = S_FETCH;
        S_ERROR:   state_next = S_ERROR;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timer <= 8'd0;
    else if (start_i || (state == S_CLEAR))
      timer <= 8'd0;
    else if (state == S_FETCH)
      timer <= mem_ack_i ? 8'd0 : timer + 8'd1;
  end

  // A request arriving in the cycle a jump is issued is re-latched for the next one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jump_pending <= 1'b0;
      jump_addr_q  <= '0;
    end else if (start_i || (state == S_CLEAR)) begin
      jump_pending <= 1'b0;
    end else if (sample_jump) begin
      jump_pending <= 1'b1;
      jump_addr_q  <= jump_addr_i;
    end else if (issuing_jump) begin
      jump_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q      <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      if (issuing_jump)
        target_q <= jump_addr_q;
      instr_valid_q <= fetch_done;
    end
  end

  always_comb begin
    pc_op_o = OP_HOLD;
    case (state)
      S_CLEAR:   pc_op_o = OP_CLEAR;
      S_ADVANCE: pc_op_o = stall_i ? OP_HOLD : OP_INC;
      S_JUMP:    pc_op_o = stall_i ? OP_HOLD : OP_LOAD;
      default:   pc_op_o = OP_HOLD;
    endcase
  end

  assign pc_target_o   = (state == S_JUMP) ? jump_addr_q : target_q;
  assign mem_req_o     = (state == S_FETCH);
  assign fetch_addr_o  = pc_val_i;
  assign instr_valid_o = instr_valid_q;
  assign busy_o        = (state != S_IDLE) && (state != S_ERROR);
  assign error_o       = (state == S_ERROR);

endmodule
